// File: rtl/lane_distrib.sv
// ---------------------------------------------------------------------------
// lane_distrib
//
// Transmit-side 2-lane distributor. It takes 16-bit words from the packet
// builder and splits them onto two HS byte streams: lane0 carries [7:0] and
// lane1 carries [15:8]. This matches the receive-side packing {lane1, lane0}.
//
// Each packet is framed as follows:
//   - hs_req, held through a prepare interval of PREP_CYCLES,
//   - one SYNC_BYTE on both lanes,
//   - the payload,
//   - per-lane trail bytes.
// Each trail byte is the complement of the last bit transmitted on that lane.
//
// Ports
//   sclk             byte clock (only clock)
//   s_rst            synchronous active-high reset
//   word_data[15:0]  payload word, [7:0] -> lane0, [15:8] -> lane1
//   word_vld         word_data valid
//   word_last        last word of packet (qualified by word_vld)
//   word_rdy         combinational; high while in DATA
//   lane0_byte_data  lane0 HS byte (registered)
//   lane1_byte_data  lane1 HS byte (registered)
//   lane0_byte_vld   lane0 byte valid (registered)
//   lane1_byte_vld   lane1 byte valid, identical to lane0_byte_vld
//   hs_req           HS mode request (registered)
//   pkt_done         one-cycle pulse, first idle lane cycle after the trail
//   underrun         one-cycle pulse when the source starves during DATA
//
// Every registered output shows the state and inputs of the previous cycle.
// As a result, hs_req rises one cycle after entering PREP and falls one cycle
// after returning to IDLE.
// ---------------------------------------------------------------------------
module lane_distrib #(
  parameter int          PREP_CYCLES  = 4,
  parameter int          TRAIL_CYCLES = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic [15:0] word_data,
  input  logic        word_vld,
  input  logic        word_last,
  output logic        word_rdy,
  output logic [7:0]  lane0_byte_data,
  output logic [7:0]  lane1_byte_data,
  output logic        lane0_byte_vld,
  output logic        lane1_byte_vld,
  output logic        hs_req,
  output logic        pkt_done,
  output logic        underrun
);

  localparam logic [3:0] PREP_LOAD  = 4'(PREP_CYCLES - 1);
  localparam logic [3:0] TRAIL_LOAD = 4'(TRAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_SYNC  = 3'd2,
    ST_DATA  = 3'd3,
    ST_TRAIL = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_prep_cnt;
  logic [3:0] w_prep_cnt_next;
  logic [3:0] r_trail_cnt;
  logic [3:0] w_trail_cnt_next;
  logic       r_msb0;
  logic       r_msb1;
  logic       w_msb0_next;
  logic       w_msb1_next;
  logic [7:0] r_lane0;
  logic [7:0] r_lane1;
  logic [7:0] w_lane0_next;
  logic [7:0] w_lane1_next;
  logic       r_vld;
  logic       w_vld_next;
  logic       r_hs_req;
  logic       r_trail_done;
  logic       w_trail_done_next;
  logic       r_pkt_done;
  logic       r_underrun;
  logic       w_underrun_next;

  // The trail byte is the complement of the lane's last MSB, repeated.
  // Because bits go out LSB-first, the MSB is the last bit on the wire.
  logic [7:0] w_trail0;
  logic [7:0] w_trail1;
  assign w_trail0 = {8{~r_msb0}};
  assign w_trail1 = {8{~r_msb1}};

  // ------------------------------------------------------------------------
  // Next-state and next-output decode
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_prep_cnt_next   = r_prep_cnt;
    w_trail_cnt_next  = r_trail_cnt;
    w_msb0_next       = r_msb0;
    w_msb1_next       = r_msb1;
    w_lane0_next      = 8'h00;
    w_lane1_next      = 8'h00;
    w_vld_next        = 1'b0;
    w_trail_done_next = 1'b0;
    w_underrun_next   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // The word only starts the packet here; it is consumed in DATA.
        if (word_vld) begin
          w_state_next    = ST_PREP;
          w_prep_cnt_next = PREP_LOAD;
        end
      end

      ST_PREP: begin
        if (r_prep_cnt == 4'd0) begin
          w_state_next = ST_SYNC;
        end else begin
          w_prep_cnt_next = r_prep_cnt - 4'd1;
        end
      end

      ST_SYNC: begin
        w_lane0_next = SYNC_BYTE;
        w_lane1_next = SYNC_BYTE;
        w_vld_next   = 1'b1;
        // If the source starves before the first word, the trail
        // follows the sync byte.
        w_msb0_next  = SYNC_BYTE[7];
        w_msb1_next  = SYNC_BYTE[7];
        w_state_next = ST_DATA;
      end

      ST_DATA: begin
        w_vld_next = 1'b1;
        if (word_vld) begin
          w_lane0_next = word_data[7:0];
          w_lane1_next = word_data[15:8];
          w_msb0_next  = word_data[7];
          w_msb1_next  = word_data[15];
          if (word_last) begin
            w_state_next     = ST_TRAIL;
            w_trail_cnt_next = TRAIL_LOAD;
          end
        end else begin
          // HS transmission cannot stall, so a starved cycle already carries
          // a trail byte. The TRAIL state then emits its full count behind it.
          w_lane0_next     = w_trail0;
          w_lane1_next     = w_trail1;
          w_underrun_next  = 1'b1;
          w_state_next     = ST_TRAIL;
          w_trail_cnt_next = TRAIL_LOAD;
        end
      end

      ST_TRAIL: begin
        w_lane0_next = w_trail0;
        w_lane1_next = w_trail1;
        w_vld_next   = 1'b1;
        if (r_trail_cnt == 4'd0) begin
          w_state_next      = ST_IDLE;
          w_trail_done_next = 1'b1;
        end else begin
          w_trail_cnt_next = r_trail_cnt - 4'd1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------------
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state      <= ST_IDLE;
      r_prep_cnt   <= 4'd0;
      r_trail_cnt  <= 4'd0;
      r_msb0       <= 1'b0;
      r_msb1       <= 1'b0;
      r_lane0      <= 8'h00;
      r_lane1      <= 8'h00;
      r_vld        <= 1'b0;
      r_hs_req     <= 1'b0;
      r_trail_done <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prep_cnt   <= w_prep_cnt_next;
      r_trail_cnt  <= w_trail_cnt_next;
      r_msb0       <= w_msb0_next;
      r_msb1       <= w_msb1_next;
      r_lane0      <= w_lane0_next;
      r_lane1      <= w_lane1_next;
      r_vld        <= w_vld_next;
      r_hs_req     <= (r_state != ST_IDLE);
      r_trail_done <= w_trail_done_next;
      // The extra stage lines pkt_done up with the first idle lane cycle.
      // In the cycle straight after TRAIL exit, the last trail byte is still
      // on the lanes.
      r_pkt_done   <= r_trail_done;
      r_underrun   <= w_underrun_next;
    end
  end

  assign word_rdy        = (r_state == ST_DATA);
  assign lane0_byte_data = r_lane0;
  assign lane1_byte_data = r_lane1;
  assign lane0_byte_vld  = r_vld;
  assign lane1_byte_vld  = r_vld;
  assign hs_req          = r_hs_req;
  assign pkt_done        = r_pkt_done;
  assign underrun        = r_underrun;

endmodule

// File: tb/tb_lane_distrib.sv
module tb_lane_distrib;

  logic        sclk = 1'b0;
  logic        s_rst;
  logic [15:0] word_data;
  logic        word_vld;
  logic        word_last;
  logic        word_rdy;
  logic [7:0]  lane0_byte_data;
  logic [7:0]  lane1_byte_data;
  logic        lane0_byte_vld;
  logic        lane1_byte_vld;
  logic        hs_req;
  logic        pkt_done;
  logic        underrun;

  int n_cmp = 0;
  int n_fail = 0;

  // Packet source table and per-cycle capture
  logic [15:0] wl_data [8];
  logic        wl_last [8];
  int          wl_stop;
  int          consumed;
  logic [7:0]  c_l0   [40];
  logic [7:0]  c_l1   [40];
  logic        c_v0   [40];
  logic        c_v1   [40];
  logic        c_hs   [40];
  logic        c_done [40];
  logic        c_und  [40];
  logic        c_rdy  [40];

  lane_distrib #(
    .PREP_CYCLES (4),
    .TRAIL_CYCLES(2),
    .SYNC_BYTE   (8'hB8)
  ) dut (
    .sclk           (sclk),
    .s_rst          (s_rst),
    .word_data      (word_data),
    .word_vld       (word_vld),
    .word_last      (word_last),
    .word_rdy       (word_rdy),
    .lane0_byte_data(lane0_byte_data),
    .lane1_byte_data(lane1_byte_data),
    .lane0_byte_vld (lane0_byte_vld),
    .lane1_byte_vld (lane1_byte_vld),
    .hs_req         (hs_req),
    .pkt_done       (pkt_done),
    .underrun       (underrun)
  );

  always #5 sclk = ~sclk;

  // Presents wl_data[idx] while idx < wl_stop and advances on each handshake.
  // Captures the outputs 1 time unit after every rising edge.
  // Capture c shows the DUT state entered at edge c (edge 0 is the first
  // edge after the call).
  task automatic run_stream(input int ncyc);
    int   idx;
    logic rdy_b;
    logic vld_b;
    idx       = 0;
    word_vld  = (wl_stop > 0);
    word_data = wl_data[0];
    word_last = wl_last[0];
    for (int c = 0; c < ncyc; c++) begin
      rdy_b = word_rdy;
      vld_b = word_vld;
      @(posedge sclk);
      #1;
      if (rdy_b && vld_b) idx++;
      c_l0[c]   = lane0_byte_data;
      c_l1[c]   = lane1_byte_data;
      c_v0[c]   = lane0_byte_vld;
      c_v1[c]   = lane1_byte_vld;
      c_hs[c]   = hs_req;
      c_done[c] = pkt_done;
      c_und[c]  = underrun;
      c_rdy[c]  = word_rdy;
      word_vld  = (idx < wl_stop);
      if (idx < 8) begin
        word_data = wl_data[idx];
        word_last = wl_last[idx];
      end
    end
    consumed = idx;
    word_vld = 1'b0;
  endtask

  task automatic test_reset();
    s_rst     = 1'b1;
    word_vld  = 1'b0;
    word_last = 1'b0;
    word_data = 16'h0000;
    repeat (3) @(posedge sclk);
    #1;
    s_rst = 1'b0;
    n_cmp++;
    if ({lane0_byte_data, lane1_byte_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_lanes: got %h expected 0000", {lane0_byte_data, lane1_byte_data});
    end
    n_cmp++;
    if ({lane0_byte_vld, lane1_byte_vld, hs_req, pkt_done, underrun, word_rdy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {lane0_byte_vld, lane1_byte_vld, hs_req, pkt_done, underrun, word_rdy});
    end
    $display("reset: outputs checked after reset release");
  endtask

  task automatic test_nominal();
    logic [7:0] e0 [12];
    logic [7:0] e1 [12];
    e0 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h34, 8'h78, 8'hBC, 8'h00, 8'h00, 8'h00};
    e1 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h12, 8'h56, 8'h9A, 8'h00, 8'h00, 8'h00};
    wl_data[0] = 16'h1234; wl_last[0] = 1'b0;
    wl_data[1] = 16'h5678; wl_last[1] = 1'b0;
    wl_data[2] = 16'h9ABC; wl_last[2] = 1'b1;
    wl_stop = 3;
    run_stream(14);
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if ({c_l0[c], c_l1[c]} !== {e0[c], e1[c]}) begin
        n_fail++;
        $display("FAIL nominal_lanes c%0d: got %h expected %h", c, {c_l0[c], c_l1[c]}, {e0[c], e1[c]});
      end
      n_cmp++;
      if ({c_v0[c], c_v1[c]} !== {2{(c >= 5 && c <= 10)}}) begin
        n_fail++;
        $display("FAIL nominal_vld c%0d: got %b expected %b", c, {c_v0[c], c_v1[c]}, {2{(c >= 5 && c <= 10)}});
      end
      n_cmp++;
      if (c_hs[c] !== (c >= 1 && c <= 10)) begin
        n_fail++;
        $display("FAIL nominal_hs c%0d: got %b expected %b", c, c_hs[c], (c >= 1 && c <= 10));
      end
      n_cmp++;
      if ({c_done[c], c_und[c], c_rdy[c]} !== {(c == 11), 1'b0, (c >= 5 && c <= 7)}) begin
        n_fail++;
        $display("FAIL nominal_ctrl c%0d: got done/und/rdy %b expected %b", c,
                 {c_done[c], c_und[c], c_rdy[c]}, {(c == 11), 1'b0, (c >= 5 && c <= 7)});
      end
    end
    n_cmp++;
    if (consumed !== 3) begin
      n_fail++;
      $display("FAIL nominal_consumed: got %0d expected 3", consumed);
    end
    $display("nominal: 3-word packet 1234/5678/9ABC checked");
  endtask

  task automatic test_trail_polarity();
    wl_data[0] = 16'hAAAA; wl_last[0] = 1'b0;
    wl_data[1] = 16'h7F80; wl_last[1] = 1'b1;
    wl_stop = 2;
    run_stream(12);
    n_cmp++;
    if ({c_l0[7], c_l1[7]} !== 16'h807F) begin
      n_fail++;
      $display("FAIL polarity_last: got %h expected 807F", {c_l0[7], c_l1[7]});
    end
    for (int c = 8; c < 10; c++) begin
      n_cmp++;
      if ({c_v0[c], c_l0[c], c_l1[c]} !== {1'b1, 8'h00, 8'hFF}) begin
        n_fail++;
        $display("FAIL polarity_trail c%0d: got vld %b %h/%h expected 1 00/FF", c, c_v0[c], c_l0[c], c_l1[c]);
      end
    end
    n_cmp++;
    if ({c_v0[10], c_done[10]} !== 2'b01) begin
      n_fail++;
      $display("FAIL polarity_end: got vld/done %b expected 01", {c_v0[10], c_done[10]});
    end
    $display("trail_polarity: last word 7F80 trail checked");
  endtask

  task automatic test_underrun();
    int und_cnt;
    und_cnt = 0;
    wl_data[0] = 16'h0102; wl_last[0] = 1'b0;
    wl_data[1] = 16'h807F; wl_last[1] = 1'b0;
    wl_data[2] = 16'h3333; wl_last[2] = 1'b0;
    wl_data[3] = 16'h4444; wl_last[3] = 1'b1;
    wl_stop = 2;
    run_stream(14);
    for (int c = 0; c < 14; c++) und_cnt += int'(c_und[c]);
    n_cmp++;
    if (und_cnt !== 1 || c_und[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_pulse: got count %0d at c8 %b expected 1 at c8", und_cnt, c_und[8]);
    end
    n_cmp++;
    if ({c_l0[7], c_l1[7]} !== 16'h7F80) begin
      n_fail++;
      $display("FAIL underrun_word2: got %h expected 7F80", {c_l0[7], c_l1[7]});
    end
    for (int c = 8; c < 11; c++) begin
      n_cmp++;
      if ({c_v0[c], c_l0[c], c_l1[c]} !== {1'b1, 8'hFF, 8'h00}) begin
        n_fail++;
        $display("FAIL underrun_trail c%0d: got vld %b %h/%h expected 1 FF/00", c, c_v0[c], c_l0[c], c_l1[c]);
      end
    end
    n_cmp++;
    if ({c_v0[11], c_done[11], c_hs[11]} !== 3'b010) begin
      n_fail++;
      $display("FAIL underrun_end: got vld/done/hs %b expected 010", {c_v0[11], c_done[11], c_hs[11]});
    end
    n_cmp++;
    if (consumed !== 2) begin
      n_fail++;
      $display("FAIL underrun_consumed: got %0d expected 2", consumed);
    end
    $display("underrun: starve after word 2 of 4 checked");
  endtask

  task automatic test_single();
    int rdy_cnt;
    rdy_cnt = 0;
    wl_data[0] = 16'h00FF; wl_last[0] = 1'b1;
    wl_stop = 1;
    run_stream(12);
    for (int c = 0; c < 12; c++) rdy_cnt += int'(c_rdy[c]);
    n_cmp++;
    if (rdy_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_rdy: got %0d cycles expected 1", rdy_cnt);
    end
    n_cmp++;
    if ({c_l0[5], c_l1[5], c_l0[6], c_l1[6]} !== 32'hB8B8FF00) begin
      n_fail++;
      $display("FAIL single_data: got %h expected B8B8FF00", {c_l0[5], c_l1[5], c_l0[6], c_l1[6]});
    end
    n_cmp++;
    if ({c_l0[7], c_l1[7], c_l0[8], c_l1[8]} !== 32'h00FF00FF) begin
      n_fail++;
      $display("FAIL single_trail: got %h expected 00FF00FF", {c_l0[7], c_l1[7], c_l0[8], c_l1[8]});
    end
    n_cmp++;
    if ({c_v0[9], c_done[9], c_v0[8], c_done[8]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL single_end: got %b expected 0110", {c_v0[9], c_done[9], c_v0[8], c_done[8]});
    end
    $display("single: one-word packet 00FF checked");
  endtask

  task automatic test_reset_mid();
    bit seen;
    int done_cnt;
    seen = 1'b0;
    done_cnt = 0;
    word_data = 16'h1234;
    word_last = 1'b0;
    word_vld  = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge sclk);
      #1;
      seen = word_rdy;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL resetmid_reach_data: got no word_rdy within 20 cycles expected word_rdy");
    end
    @(posedge sclk);
    #1;
    s_rst = 1'b1;
    @(posedge sclk);
    #1;
    s_rst    = 1'b0;
    word_vld = 1'b0;
    n_cmp++;
    if ({lane0_byte_data, lane1_byte_data, lane0_byte_vld, lane1_byte_vld, hs_req, pkt_done, underrun, word_rdy}
        !== 22'b0) begin
      n_fail++;
      $display("FAIL resetmid_outputs: got %h/%h ctrl %b expected all 0", lane0_byte_data, lane1_byte_data,
               {lane0_byte_vld, lane1_byte_vld, hs_req, pkt_done, underrun, word_rdy});
    end
    repeat (12) begin
      @(posedge sclk);
      #1;
      done_cnt += int'(pkt_done) + int'(lane0_byte_vld);
    end
    n_cmp++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL resetmid_no_done: got %0d done/vld cycles expected 0", done_cnt);
    end
    $display("reset_mid: reset during DATA checked");
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    done_cnt = 0;
    wl_data[0] = 16'h1357; wl_last[0] = 1'b1;
    wl_data[1] = 16'h2468; wl_last[1] = 1'b1;
    wl_stop = 2;
    run_stream(20);
    for (int c = 0; c < 20; c++) begin
      done_cnt += int'(c_done[c]);
      n_cmp++;
      if (c_v0[c] !== c_v1[c]) begin
        n_fail++;
        $display("FAIL b2b_vld_match c%0d: got %b/%b expected equal", c, c_v0[c], c_v1[c]);
      end
    end
    n_cmp++;
    if ({c_l0[5], c_l1[5], c_l0[6], c_l1[6]} !== 32'hB8B85713) begin
      n_fail++;
      $display("FAIL b2b_pkt1: got %h expected B8B85713", {c_l0[5], c_l1[5], c_l0[6], c_l1[6]});
    end
    n_cmp++;
    if ({c_v0[9], c_hs[9], c_done[9], c_hs[10]} !== 4'b0011) begin
      n_fail++;
      $display("FAIL b2b_gap: got vld/hs/done/hs_next %b expected 0011", {c_v0[9], c_hs[9], c_done[9], c_hs[10]});
    end
    n_cmp++;
    if ({c_l0[14], c_l1[14], c_l0[15], c_l1[15], c_l0[16], c_l1[16]} !== 48'hB8B86824FFFF) begin
      n_fail++;
      $display("FAIL b2b_pkt2: got %h expected B8B86824FFFF",
               {c_l0[14], c_l1[14], c_l0[15], c_l1[15], c_l0[16], c_l1[16]});
    end
    n_cmp++;
    if (done_cnt !== 2 || c_done[18] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses c18 %b expected 2 with c18 1", done_cnt, c_done[18]);
    end
    $display("back_to_back: two packets 1357 and 2468 checked");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_trail_polarity();
    test_underrun();
    test_single();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
